// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin write arbiter feeding a register file write port.
// Grants are combinational; the winning write is registered one cycle toward the file.
`timescale 1ns/1ps
module regfile_wr_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [7:0]        cnt_a,
  output logic [7:0]        cnt_b,
  output logic              last_gnt
);

  logic              rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [7:0]        cnt_a_q,    cnt_a_d;
  logic [7:0]        cnt_b_q,    cnt_b_d;
  logic              last_gnt_q, last_gnt_d;

  // Grant selection; under contention the side that did not win last time goes first.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n && en) begin
      if (a_req && b_req) begin
        a_gnt = last_gnt_q;
        b_gnt = ~last_gnt_q;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end else begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
  end

  // Next-state for the registered write port, counters and priority pointer.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    last_gnt_d = last_gnt_q;
    if (a_req && a_gnt) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = a_addr;
      rf_wdata_d = a_data;
      cnt_a_d    = cnt_a_q + 8'd1;
      last_gnt_d = 1'b0;
    end else if (b_req && b_gnt) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = b_addr;
      rf_wdata_d = b_data;
      cnt_b_d    = cnt_b_q + 8'd1;
      last_gnt_d = 1'b1;
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // State registers; reset leaves A with first priority and kills any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {ADDR_W{1'b0}};
      rf_wdata_q <= {DATA_W{1'b0}};
      cnt_a_q    <= 8'd0;
      cnt_b_q    <= 8'd0;
      last_gnt_q <= 1'b1;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;
  assign last_gnt = last_gnt_q;

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of the write data to the register file.
REQ-002 Parameter ADDR_W, default 3, width of the register address (8 entries).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port en  input  1  arbitration enable; when low, no grant SHALL be issued.
REQ-006 Port a_req  input  1  requester A write request, held until granted.
REQ-007 Port a_addr  input  ADDR_W  requester A target register.
REQ-008 Port a_data  input  DATA_W  requester A write data.
REQ-009 Port a_gnt  output  1  grant to A; a transfer occurs when a_req && a_gnt at the clock edge.
REQ-010 Port b_req, b_addr, b_data, b_gnt SHALL behave as the A ports, for requester B.
REQ-011 Port rf_we  output  1  registered write enable to the register file.
REQ-012 Port rf_waddr  output  ADDR_W  registered write address to the register file.
REQ-013 Port rf_wdata  output  DATA_W  registered write data to the register file.
REQ-014 Port cnt_a  output  8  count of transfers accepted from A.
REQ-015 Port cnt_b  output  8  count of transfers accepted from B.
REQ-016 Port last_gnt  output  1  last requester granted; 0=A, 1=B.

Function
REQ-017 a_gnt and b_gnt SHALL be combinational from en, a_req, b_req and the priority pointer; they SHALL never both be high.
REQ-018 A grant SHALL only be issued to a requester whose req is high.
REQ-019 When en=1 and only one requester asserts req, that requester SHALL be granted the same cycle.
REQ-020 When en=1 and both requesters assert req, the requester not equal to last_gnt SHALL be granted (round-robin).
REQ-021 On each transfer, last_gnt SHALL update to the granted requester at that edge.
REQ-022 On the edge of a transfer, rf_we SHALL load 1, and rf_waddr/rf_wdata SHALL load the granted requester's addr/data.
REQ-023 Latency: a transfer at edge N SHALL present rf_we=1 during cycle N..N+1, so the register file captures the data at edge N+1.
REQ-024 On an edge with no transfer, rf_we SHALL load 0; rf_waddr and rf_wdata SHALL hold their values.
REQ-025 Back-to-back transfers SHALL be supported with rf_we high on consecutive cycles; throughput is 1 write per cycle.
REQ-026 cnt_a/cnt_b SHALL increment by 1 per accepted transfer of their requester and SHALL wrap 255->0.
REQ-027 Same-address requests from A and B SHALL be serialized in grant order without merging; the later write wins in the register file.
REQ-028 en deasserted SHALL block new grants only; an rf_we already registered SHALL still complete in the following cycle.
REQ-029 A requester that drops req before being granted SHALL cause no transfer and no counter change.

Reset
REQ-030 While rst_n=0: rf_we=0, rf_waddr=0, rf_wdata=0, cnt_a=0, cnt_b=0, last_gnt=1 (A has first priority); a_gnt and b_gnt SHALL be 0 regardless of req.
REQ-031 Reset asserted mid-operation SHALL clear rf_we immediately (asynchronously), so no register-file write completes after the reset edge.
REQ-032 After rst_n rises, the first simultaneous A/B request SHALL be granted to A.

Verification
REQ-033 Single request: after reset, a_req=1, a_addr=0, a_data=AA for one cycle -> a_gnt=1, next cycle rf_we=1, rf_waddr=0, rf_wdata=AA, cnt_a=1.
REQ-034 Contention: a_req=b_req=1 held with (addr 1, 55) and (addr 2, 33) -> grants alternate A,B,A,B; rf_we stays high; cnt_a and cnt_b track the grants.
REQ-035 Same address: A (3, 11) and B (3, 22) requested together -> A then B written on consecutive cycles; register 3 reads 22 afterwards.
REQ-036 Enable gating: en=0 with both requests -> no grants and rf_we=0; raising en -> grant per the pointer.
REQ-037 Wrap: 256 accepted A transfers -> cnt_a returns to 0 and cnt_b is unchanged.
REQ-038 Mid-write reset: rst_n pulsed low for 3 ns in the cycle after a grant -> rf_we drops at once, all outputs return to the REQ-030 values, and the target register is unchanged.
